gmii_tx_arbiter: RTL and testbench

GMII_TX_ARBITER -- requirements
Module: gmii_tx_arbiter

---
 rtl/eth_pkg.sv | 24 ++
 rtl/tx_rr_select.sv | 28 ++
 rtl/gmii_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_gmii_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: arbiter state encoding, source indices and
// the default inter-frame gap, reused by the arp, icmp and cmos2eth senders.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_SEND  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_IFG   = 3'd4
    } tx_state_t;

    localparam logic [1:0] SRC_ARP  = 2'd0;
    localparam logic [1:0] SRC_ICMP = 2'd1;
    localparam logic [1:0] SRC_CAM1 = 2'd2;
    localparam logic [1:0] SRC_CAM2 = 2'd3;

    localparam int IFG_DEFAULT = 12;

    function automatic logic [3:0] src_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/tx_rr_select.sv
// Combinational TX winner: ARP beats ICMP beats the camera pair, and the two
// camera streams share their slot round-robin via the registered pointer.
module tx_rr_select
    import eth_pkg::*;
(
    input  logic [3:0] req,
    input  logic       prefer_cam2,
    output logic       valid,
    output logic [1:0] winner
);

    always_comb begin
        valid  = |req;
        winner = SRC_ARP;
        if (req[SRC_ARP]) begin
            winner = SRC_ARP;
        end else if (req[SRC_ICMP]) begin
            winner = SRC_ICMP;
        end else if (req[SRC_CAM1] && req[SRC_CAM2]) begin
            winner = prefer_cam2 ? SRC_CAM2 : SRC_CAM1;
        end else if (req[SRC_CAM1]) begin
            winner = SRC_CAM1;
        end else if (req[SRC_CAM2]) begin
            winner = SRC_CAM2;
        end
    end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Merges four GMII TX sources onto one output: grants one frame at a time,
// forwards it with one cycle of latency and enforces the inter-frame gap.
module gmii_tx_arbiter
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES  = IFG_DEFAULT,
    parameter int GNT_TIMEOUT = 64,
    parameter int MAX_FRAME   = 2000
) (
    input  logic        eth_clk,
    input  logic        rst_n,
    input  logic [3:0]  src_req,
    input  logic [3:0]  src_txctl,
    input  logic [31:0] src_txd,
    output logic [3:0]  src_gnt,
    output logic        gmii_eth_txctl,
    output logic [7:0]  gmii_eth_txd,
    output logic        busy,
    output logic [1:0]  cur_src,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam logic [15:0] GNT_LAST = 16'(GNT_TIMEOUT - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
    localparam logic [10:0] LEN_MAX  = 11'(MAX_FRAME);

    // Handshake: a source holds src_req high until its frame is done; once
    // src_gnt is seen it raises src_txctl within GNT_TIMEOUT cycles and keeps
    // it high for the whole frame; the first low txctl ends the frame.
    tx_state_t   state, state_n;
    logic [3:0]  gnt_n;
    logic [1:0]  cur_n;
    logic        txctl_n;
    logic [7:0]  txd_n;
    logic        err_t_n, err_o_n;
    logic [10:0] len_cnt, len_n;
    logic [15:0] tmr_cnt, tmr_n;
    logic        rr_cam2, rr_n;

    logic        sel_valid;
    logic [1:0]  sel_winner;
    logic [4:0]  byte_lsb;
    logic        cur_txctl;
    logic [7:0]  cur_txd;

    tx_rr_select u_select (
        .req         (src_req),
        .prefer_cam2 (rr_cam2),
        .valid       (sel_valid),
        .winner      (sel_winner)
    );

    assign byte_lsb  = {cur_src, 3'b000};
    assign cur_txctl = src_txctl[cur_src];
    assign cur_txd   = src_txd[byte_lsb +: 8];
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge eth_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            src_gnt        <= 4'b0000;
            cur_src        <= SRC_ARP;
            gmii_eth_txctl <= 1'b0;
            gmii_eth_txd   <= 8'h00;
            err_timeout    <= 1'b0;
            err_overrun    <= 1'b0;
            len_cnt        <= 11'd0;
            tmr_cnt        <= 16'd0;
            rr_cam2        <= 1'b0;
        end else begin
            state          <= state_n;
            src_gnt        <= gnt_n;
            cur_src        <= cur_n;
            gmii_eth_txctl <= txctl_n;
            gmii_eth_txd   <= txd_n;
            err_timeout    <= err_t_n;
            err_overrun    <= err_o_n;
            len_cnt        <= len_n;
            tmr_cnt        <= tmr_n;
            rr_cam2        <= rr_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = src_gnt;
        cur_n   = cur_src;
        txctl_n = 1'b0;
        txd_n   = 8'h00;
        err_t_n = 1'b0;
        err_o_n = 1'b0;
        len_n   = len_cnt;
        tmr_n   = tmr_cnt;
        rr_n    = rr_cam2;
        case (state)
            ST_IDLE: begin
                len_n = 11'd0;
                tmr_n = 16'd0;
                if (sel_valid) begin
                    gnt_n   = src_onehot(sel_winner);
                    cur_n   = sel_winner;
                    state_n = ST_GRANT;
                    // Point the camera slot at the stream not just served.
                    if (sel_winner == SRC_CAM1) begin
                        rr_n = 1'b1;
                    end else if (sel_winner == SRC_CAM2) begin
                        rr_n = 1'b0;
                    end
                end
            end
            ST_GRANT: begin
                if (!src_req[cur_src]) begin
                    gnt_n   = 4'b0000;
                    tmr_n   = 16'd0;
                    state_n = ST_IFG;
                end else if (cur_txctl) begin
                    txctl_n = 1'b1;
                    txd_n   = cur_txd;
                    len_n   = 11'd1;
                    state_n = ST_SEND;
                end else if (tmr_cnt == GNT_LAST) begin
                    gnt_n   = 4'b0000;
                    err_t_n = 1'b1;
                    tmr_n   = 16'd0;
                    state_n = ST_IFG;
                end else begin
                    tmr_n = tmr_cnt + 16'd1;
                end
            end
            ST_SEND: begin
                if (!cur_txctl) begin
                    gnt_n   = 4'b0000;
                    tmr_n   = 16'd0;
                    state_n = ST_IFG;
                end else if (len_cnt == LEN_MAX) begin
                    gnt_n   = 4'b0000;
                    err_o_n = 1'b1;
                    state_n = ST_DRAIN;
                end else begin
                    txctl_n = 1'b1;
                    txd_n   = cur_txd;
                    len_n   = len_cnt + 11'd1;
                end
            end
            ST_DRAIN: begin
                // Swallow the rest of a truncated frame before the gap starts.
                if (!cur_txctl) begin
                    tmr_n   = 16'd0;
                    state_n = ST_IFG;
                end
            end
            ST_IFG: begin
                if (tmr_cnt == IFG_LAST) begin
                    tmr_n   = 16'd0;
                    state_n = ST_IDLE;
                end else begin
                    tmr_n = tmr_cnt + 16'd1;
                end
            end
            default: begin
                gnt_n   = 4'b0000;
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter: byte scoreboard on the merged output,
// grant-order log and per-scenario checks of gaps, timeouts and truncation.
module tb_gmii_tx_arbiter;

    logic        eth_clk;
    logic        rst_n;
    logic [3:0]  src_req;
    logic [3:0]  src_txctl;
    logic [31:0] src_txd;
    logic [3:0]  src_gnt;
    logic        gmii_eth_txctl;
    logic [7:0]  gmii_eth_txd;
    logic        busy;
    logic [1:0]  cur_src;
    logic        err_timeout;
    logic        err_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    int         gnt_log[$];
    int         gap_q[$];
    int         n_err_t = 0;
    int         n_err_o = 0;
    int         n_hi    = 0;

    gmii_tx_arbiter dut (
        .eth_clk        (eth_clk),
        .rst_n          (rst_n),
        .src_req        (src_req),
        .src_txctl      (src_txctl),
        .src_txd        (src_txd),
        .src_gnt        (src_gnt),
        .gmii_eth_txctl (gmii_eth_txctl),
        .gmii_eth_txd   (gmii_eth_txd),
        .busy           (busy),
        .cur_src        (cur_src),
        .err_timeout    (err_timeout),
        .err_overrun    (err_overrun)
    );

    // clock / watchdog
    initial eth_clk = 1'b0;
    always #4 eth_clk = ~eth_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard / monitor, sampled 1 time unit after each rising edge
    initial begin
        logic       exp_txctl;
        logic [7:0] exp_txd;
        logic [3:0] prev_gnt;
        logic       prev_tx;
        logic       seen_frame;
        int         idle_run;
        int         idx;
        prev_gnt   = 4'b0000;
        prev_tx    = 1'b0;
        seen_frame = 1'b0;
        idle_run   = 0;
        forever begin
            @(posedge eth_clk);
            #1;
            exp_txctl = (exp_q.size() != 0);
            exp_txd   = exp_txctl ? exp_q.pop_front() : 8'h00;
            check("txctl", {31'd0, gmii_eth_txctl}, {31'd0, exp_txctl});
            check("txd", {24'd0, gmii_eth_txd}, {24'd0, exp_txd});
            check("gnt_onehot0", {31'd0, $onehot0(src_gnt)}, 32'd1);
            if (err_timeout) n_err_t++;
            if (err_overrun) n_err_o++;
            if (gmii_eth_txctl) n_hi++;
            if (src_gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (src_gnt[k]) idx = k;
                gnt_log.push_back(idx);
            end
            prev_gnt = src_gnt;
            if (gmii_eth_txctl) begin
                if (!prev_tx && seen_frame) gap_q.push_back(idle_run);
                idle_run   = 0;
                seen_frame = 1'b1;
            end else begin
                idle_run++;
            end
            prev_tx = gmii_eth_txctl;
        end
    end

    // driver tasks; all input changes happen on falling edges
    task automatic send_frame(input int src, input int dly, input int len,
                              input int n_push, input bit drop_req);
        int t;
        t = 0;
        while (!src_gnt[src] && t < 3000) begin
            @(negedge eth_clk);
            t++;
        end
        check($sformatf("gnt_seen_src%0d", src), {31'd0, src_gnt[src]}, 32'd1);
        if (!src_gnt[src]) begin
            src_req[src] = 1'b0;
            return;
        end
        check($sformatf("cur_src_src%0d", src), {30'd0, cur_src}, 32'(src));
        repeat (dly) @(negedge eth_clk);
        for (int i = 0; i < len; i++) begin
            src_txctl[src]        = 1'b1;
            src_txd[8*src +: 8]   = 8'(i);
            if (i < n_push) exp_q.push_back(8'(i));
            @(negedge eth_clk);
        end
        src_txctl[src]      = 1'b0;
        src_txd[8*src +: 8] = 8'h00;
        if (drop_req) src_req[src] = 1'b0;
        @(negedge eth_clk);
        check($sformatf("gnt_drop_src%0d", src), {31'd0, src_gnt[src]}, 32'd0);
    endtask

    task automatic responder(input int src, input int n_frames, input int len);
        for (int f = 0; f < n_frames; f++)
            send_frame(src, 1, len, len, (f == n_frames - 1));
    endtask

    task automatic busy_tail(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge eth_clk);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 3000) begin
            @(negedge eth_clk);
            t++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int e0;
        int h0;
        rst_n     = 1'b0;
        src_req   = 4'b0000;
        src_txctl = 4'b0000;
        src_txd   = 32'h0;

        // reset values
        @(negedge eth_clk);
        check("rst_gnt", {28'd0, src_gnt}, 32'd0);
        check("rst_txctl", {31'd0, gmii_eth_txctl}, 32'd0);
        check("rst_txd", {24'd0, gmii_eth_txd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cur_src", {30'd0, cur_src}, 32'd0);
        check("rst_err", {30'd0, err_timeout, err_overrun}, 32'd0);
        repeat (2) @(negedge eth_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge eth_clk);

        // priority order with all of 0, 2, 3 pending at once
        gnt_log.delete();
        gap_q.delete();
        src_req = 4'b1101;
        fork
            send_frame(0, 1, 30, 30, 1'b1);
            send_frame(2, 2, 40, 40, 1'b1);
            send_frame(3, 0, 20, 20, 1'b1);
        join
        busy_tail(n);
        check("prio_tail_ifg", 32'(n), 32'd12);
        check("prio_n_grants", 32'(gnt_log.size()), 32'd3);
        if (gnt_log.size() == 3) begin
            check("prio_first", 32'(gnt_log[0]), 32'd0);
            check("prio_second", 32'(gnt_log[1]), 32'd2);
            check("prio_third", 32'(gnt_log[2]), 32'd3);
        end
        check("prio_n_gaps", 32'(gap_q.size()), 32'd2);
        foreach (gap_q[i]) check("prio_gap_ge12", {31'd0, gap_q[i] >= 12}, 32'd1);

        // round-robin between the two camera streams
        gnt_log.delete();
        gap_q.delete();
        src_req[2] = 1'b1;
        src_req[3] = 1'b1;
        fork
            responder(2, 2, 60);
            responder(3, 2, 60);
        join
        wait_idle();
        check("rr_n_grants", 32'(gnt_log.size()), 32'd4);
        if (gnt_log.size() == 4) begin
            check("rr_g0", 32'(gnt_log[0]), 32'd2);
            check("rr_g1", 32'(gnt_log[1]), 32'd3);
            check("rr_g2", 32'(gnt_log[2]), 32'd2);
            check("rr_g3", 32'(gnt_log[3]), 32'd3);
        end
        foreach (gap_q[i]) check("rr_gap_ge12", {31'd0, gap_q[i] >= 12}, 32'd1);

        // ungranted txctl in IDLE never reaches the output
        src_txctl[1]   = 1'b1;
        src_txd[15:8]  = 8'h5A;
        repeat (5) @(negedge eth_clk);
        check("leak_idle_busy", {31'd0, busy}, 32'd0);
        check("leak_idle_gnt", {28'd0, src_gnt}, 32'd0);
        src_txctl[1]  = 1'b0;
        src_txd[15:8] = 8'h00;

        // single src2 frame of 100 bytes, with src3 chattering ungranted
        h0 = n_hi;
        src_req[2] = 1'b1;
        fork
            send_frame(2, 3, 100, 100, 1'b1);
            begin
                repeat (10) @(negedge eth_clk);
                src_txctl[3]   = 1'b1;
                src_txd[31:24] = 8'hA5;
                repeat (40) @(negedge eth_clk);
                src_txctl[3]   = 1'b0;
                src_txd[31:24] = 8'h00;
            end
        join
        busy_tail(n);
        check("single_tail_ifg", 32'(n), 32'd12);
        check("single_hi_cycles", 32'(n_hi - h0), 32'd100);

        // grant timeout: src1 never raises txctl
        e0 = n_err_t;
        h0 = n_hi;
        src_req[1] = 1'b1;
        n = 0;
        while (!src_gnt[1] && n < 20) begin
            @(negedge eth_clk);
            n++;
        end
        check("tmo_gnt_seen", {31'd0, src_gnt[1]}, 32'd1);
        n = 0;
        while (src_gnt[1] && n < 200) begin
            n++;
            @(negedge eth_clk);
        end
        src_req[1] = 1'b0;
        check("tmo_gnt_cycles", 32'(n), 32'd64);
        repeat (3) @(negedge eth_clk);
        check("tmo_err_pulses", 32'(n_err_t - e0), 32'd1);
        check("tmo_out_idle", 32'(n_hi - h0), 32'd0);
        wait_idle();

        // request withdrawn while granted: grant drops, no error
        e0 = n_err_t;
        src_req[1] = 1'b1;
        n = 0;
        while (!src_gnt[1] && n < 20) begin
            @(negedge eth_clk);
            n++;
        end
        check("wd_gnt_seen", {31'd0, src_gnt[1]}, 32'd1);
        src_req[1] = 1'b0;
        @(negedge eth_clk);
        check("wd_gnt_dropped", {28'd0, src_gnt}, 32'd0);
        check("wd_busy_ifg", {31'd0, busy}, 32'd1);
        wait_idle();
        check("wd_no_err", 32'(n_err_t - e0), 32'd0);

        // overrun: 2100-cycle frame truncated to 2000
        e0 = n_err_o;
        h0 = n_hi;
        src_req[3] = 1'b1;
        send_frame(3, 0, 2100, 2000, 1'b1);
        busy_tail(n);
        check("ovr_tail_ifg", 32'(n), 32'd12);
        check("ovr_hi_cycles", 32'(n_hi - h0), 32'd2000);
        check("ovr_err_pulses", 32'(n_err_o - e0), 32'd1);

        // reset in the middle of a src0 frame
        src_req[0] = 1'b1;
        n = 0;
        while (!src_gnt[0] && n < 20) begin
            @(negedge eth_clk);
            n++;
        end
        check("mrst_gnt_seen", {31'd0, src_gnt[0]}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            src_txctl[0]  = 1'b1;
            src_txd[7:0]  = 8'(i);
            exp_q.push_back(8'(i));
            @(negedge eth_clk);
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mrst_txctl", {31'd0, gmii_eth_txctl}, 32'd0);
        check("mrst_txd", {24'd0, gmii_eth_txd}, 32'd0);
        check("mrst_gnt", {28'd0, src_gnt}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_cur_src", {30'd0, cur_src}, 32'd0);
        repeat (2) @(negedge eth_clk);
        rst_n        = 1'b1;
        src_txctl[0] = 1'b0;
        src_txd[7:0] = 8'h00;
        @(negedge eth_clk);
        check("mrst_regrant", {28'd0, src_gnt}, 32'd1);
        send_frame(0, 0, 10, 10, 1'b1);
        busy_tail(n);
        check("mrst_tail_ifg", 32'(n), 32'd12);

        repeat (3) @(negedge eth_clk);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
